// File: rtl/uart2_rx.sv
`default_nettype none
// ============================================================================
// uart2_rx : 16x-oversampled UART receiver (8N1) with one-cycle valid and
//            framing-error strobes. Define UART2_RX_PARITY_EN for even parity.
// Revision : 1.0
// ============================================================================
module uart2_rx #(
  parameter int BAUD_DIV  = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_sis,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
`ifdef UART2_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
`ifdef UART2_RX_PARITY_EN
    , S_PARITY  = 3'd5
`endif
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s, rx_prev;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic [3:0]           samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 start_det, start_ok, shift_en, accept, reject;
`ifdef UART2_RX_PARITY_EN
  logic                 par_en, par_bit;
`endif

  assign tick = (state != S_IDLE) && (state != S_WAIT_IDLE) && (tick_cnt == TICK_LAST);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    start_det = 1'b0;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
`ifdef UART2_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n   = S_START;
          start_det = 1'b1;
        end
      end
      S_START: begin
        // Half a bit into the start bit: a high line here was only a glitch.
        if (tick && samp_cnt == 4'd7) begin
          if (!rx_s) begin
            state_n  = S_DATA;
            start_ok = 1'b1;
          end else begin
            state_n  = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick && samp_cnt == 4'd15) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART2_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART2_RX_PARITY_EN
      S_PARITY: begin
        if (tick && samp_cnt == 4'd15) begin
          par_en  = 1'b1;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Deciding mid stop bit lets a zero-gap start edge be caught in IDLE.
        if (tick && samp_cnt == 4'd15) begin
          if (rx_s) begin
            accept  = 1'b1;
            state_n = S_IDLE;
          end else begin
            reject  = 1'b1;
            state_n = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      tick_cnt   <= '0;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      data_valid <= accept;
      frame_err  <= reject;

      if (state == S_IDLE || state == S_WAIT_IDLE || start_det || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end

      if (start_det || start_ok) begin
        samp_cnt <= '0;
      end else if (tick) begin
        samp_cnt <= samp_cnt + 4'd1;
      end

      if (start_det) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
      end

      // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
      if (shift_en) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end

      if (accept) begin
        data_out <= shreg;
      end
    end
  end

`ifdef UART2_RX_PARITY_EN
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) begin
        par_bit <= rx_s;
      end
      parity_err <= accept & ((^shreg) ^ par_bit);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart2_rx.sv
`default_nettype none
// tb_uart2_rx : randomized self-checking bench for uart2_rx against a
//               frame-level reference model (expected events and latency).
module tb_uart2_rx;

  localparam int BD  = 8;
  localparam int DB  = 8;
  localparam int BIT = 16 * BD;
`ifdef UART2_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT   = 2 + 8 * BD + (DB + 1 + PB) * 16 * BD + 1;
  localparam int FRAME = (DB + 2 + PB) * BIT;

  logic          clk_sis = 1'b0;
  logic          rst     = 1'b0;
  logic          rx      = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid, frame_err, busy;
`ifdef UART2_RX_PARITY_EN
  logic          parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit            is_err;
    bit            perr;
    logic [DB-1:0] data;
    int            cyc;
  } ev_t;

  ev_t           evq[$];
  logic [DB-1:0] model_out;

  uart2_rx #(.BAUD_DIV(BD), .DATA_BITS(DB)) dut (
    .clk_sis    (clk_sis),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
`ifdef UART2_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk_sis = ~clk_sis;
  always @(posedge clk_sis) cyc <= cyc + 1;

  always @(negedge clk_sis) begin : mon
    ev_t e;
    if (rst && (data_valid || frame_err)) begin
      e.is_err = frame_err;
      e.data   = data_out;
      e.cyc    = cyc;
`ifdef UART2_RX_PARITY_EN
      e.perr   = parity_err;
`else
      e.perr   = 1'b0;
`endif
      evq.push_back(e);
      n_checks++;
      if (data_valid && frame_err) begin
        n_fail++;
        $display("FAIL strobe_excl: data_valid=%b frame_err=%b, required not both", data_valid, frame_err);
      end
    end
  end

  task automatic hold(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(negedge clk_sis);
  endtask

  task automatic send_head(input logic [DB-1:0] b, input bit par_flip, output int t_start);
    t_start = cyc;
    hold(1'b0, BIT);
    for (int i = 0; i < DB; i++) hold(b[i], BIT);
    if (PB == 1) hold((^b) ^ par_flip, BIT);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input bit par_flip, output int t_start);
    send_head(b, par_flip, t_start);
    hold(1'b1, BIT);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (4) @(negedge clk_sis);
    n_checks += 4;
    if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h, required 00", data_out); end
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b, required 0", data_valid); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b1;
    hold(1'b1, 2 * BIT);
    model_out = '0;
  endtask

  task automatic test_single;
    int ts;
    evq.delete();
    send_frame(8'hA5, 1'b0, ts);
    repeat (16) @(negedge clk_sis);
    model_out = 8'hA5;
    n_checks++;
    if (evq.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d events, required 1", evq.size());
    end else begin
      n_checks += 3;
      if (evq[0].is_err) begin n_fail++; $display("FAIL single_kind: got frame_err, required data_valid"); end
      if (evq[0].data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h, required a5", evq[0].data); end
      if (evq[0].cyc - ts < LAT - 1 || evq[0].cyc - ts > LAT + 1) begin
        n_fail++; $display("FAIL single_latency: got %0d, required %0d+-1", evq[0].cyc - ts, LAT);
      end
    end
    n_checks++;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: data_valid=%b, required 0", data_valid); end
  endtask

  task automatic test_glitch;
    int t0;
    evq.delete();
    t0 = cyc;
    hold(1'b0, 10);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b, required 1", busy); end
    hold(1'b0, 22);
    rx = 1'b1;
    while (busy && (cyc - t0) < 80) @(negedge clk_sis);
    n_checks++;
    if (busy !== 1'b0 || (cyc - t0) > 70) begin
      n_fail++; $display("FAIL glitch_busy_low: busy=%b after %0d cycles, required 0 within 70", busy, cyc - t0);
    end
    hold(1'b1, 3 * BIT);
    n_checks++;
    if (evq.size() != 0) begin n_fail++; $display("FAIL glitch_events: got %0d, required 0", evq.size()); end
  endtask

  task automatic test_break;
    int ts, t0;
    evq.delete();
    send_head(8'h3C, 1'b0, ts);
    hold(1'b0, 3 * BIT);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_high: got %b, required 1", busy); end
    rx = 1'b1;
    t0 = cyc;
    while (busy && (cyc - t0) < 10) @(negedge clk_sis);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_low: got %b, required 0", busy); end
    hold(1'b1, BIT);
    n_checks += 2;
    if (evq.size() != 1 || !evq[0].is_err) begin
      n_fail++; $display("FAIL break_events: got %0d events, required exactly one frame_err", evq.size());
    end
    if (data_out !== model_out) begin n_fail++; $display("FAIL break_data_out: got %h, required %h", data_out, model_out); end
  endtask

  task automatic test_back_to_back;
    int ts0, ts1;
    evq.delete();
    send_frame(8'h00, 1'b0, ts0);
    send_frame(8'hFF, 1'b0, ts1);
    repeat (16) @(negedge clk_sis);
    model_out = 8'hFF;
    n_checks++;
    if (evq.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d events, required 2", evq.size());
    end else begin
      n_checks += 3;
      if (evq[0].is_err || evq[0].data !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h err=%b, required 00", evq[0].data, evq[0].is_err); end
      if (evq[1].is_err || evq[1].data !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h err=%b, required ff", evq[1].data, evq[1].is_err); end
      if (evq[1].cyc - evq[0].cyc != FRAME) begin n_fail++; $display("FAIL b2b_spacing: got %0d, required %0d", evq[1].cyc - evq[0].cyc, FRAME); end
    end
  endtask

  task automatic test_reset_mid;
    int ts;
    logic [DB-1:0] b;
    evq.delete();
    b = 8'h81;
    ts = cyc;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(b[i], BIT);
    hold(b[4], BIT / 2);
    #2 rst = 1'b0;
    #1;
    n_checks += 2;
    if (data_out !== '0 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: data_out=%h dv=%b fe=%b, required all 0", data_out, data_valid, frame_err);
    end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    @(negedge clk_sis);
    hold(1'b1, 20);
    rst = 1'b1;
    hold(1'b1, 2 * BIT);
    model_out = '0;
    send_frame(8'h5A, 1'b0, ts);
    repeat (16) @(negedge clk_sis);
    model_out = 8'h5A;
    n_checks++;
    if (evq.size() != 1 || evq[0].is_err || evq[0].data !== 8'h5A) begin
      n_fail++; $display("FAIL rstmid_recover: got %0d events data_out=%h, required one 5a", evq.size(), data_out);
    end
  endtask

  task automatic test_random;
    logic [DB-1:0] bytes[8];
    bit            good[8];
    int            starts[8];
    int            ts, gap;
    logic [DB-1:0] exp_out;
    evq.delete();
    exp_out = model_out;
    for (int k = 0; k < 8; k++) begin
      bytes[k] = DB'($urandom);
      good[k]  = ($urandom_range(0, 3) != 0);
      if (good[k]) begin
        send_frame(bytes[k], 1'b0, ts);
      end else begin
        send_head(bytes[k], 1'b0, ts);
        hold(1'b0, 2 * BIT);
        hold(1'b1, BIT);
      end
      starts[k] = ts;
      gap = $urandom_range(0, 2);
      if (gap > 0) hold(1'b1, gap * BIT);
    end
    repeat (16) @(negedge clk_sis);
    n_checks++;
    if (evq.size() != 8) begin
      n_fail++; $display("FAIL rand_count: got %0d events, required 8", evq.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (good[k]) exp_out = bytes[k];
        n_checks++;
        if (evq[k].is_err == good[k] || evq[k].data !== exp_out || evq[k].cyc - starts[k] != LAT) begin
          n_fail++;
          $display("FAIL rand_frame%0d: err=%b data=%h lat=%0d, required err=%b data=%h lat=%0d",
                   k, evq[k].is_err, evq[k].data, evq[k].cyc - starts[k], !good[k], exp_out, LAT);
        end
      end
    end
    for (int k = 0; k < 8; k++) if (good[k]) model_out = bytes[k];
    n_checks++;
    if (data_out !== model_out) begin n_fail++; $display("FAIL rand_hold: got %h, required %h", data_out, model_out); end
  endtask

`ifdef UART2_RX_PARITY_EN
  task automatic test_parity;
    int ts;
    for (int f = 0; f < 2; f++) begin
      evq.delete();
      send_frame(8'h07, f[0], ts);
      repeat (16) @(negedge clk_sis);
      n_checks++;
      if (evq.size() != 1 || evq[0].is_err || evq[0].data !== 8'h07 || evq[0].perr != f[0]) begin
        n_fail++; $display("FAIL parity_%0d: got %0d events perr=%b data=%h, required perr=%b data 07",
                           f, evq.size(), (evq.size() > 0) ? evq[0].perr : 1'b0, data_out, f[0]);
      end
    end
    model_out = 8'h07;
  endtask
`endif

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk_sis);
    test_reset();
    test_single();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef UART2_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
